ti_clock_gen: RTL and testbench

Synthesizable multi-phase sampling-clock generator for the time-interleaved SAR-ADC model. It divides one master clock into N_CH phase-staggered sampling pulses, one per sub-ADC slice. Each pulse has a programmable slot period and high time, and each channel can be masked. It extends the single-channel ideal generator with counters, runtime reconfiguration applied glitch-free at frame boundaries, and config error reporting.

---
 rtl/ti_clock_pkg.sv | 24 ++
 rtl/ti_slot_counter.sv | 52 +++++
 rtl/ti_clock_gen.sv | 136 +++++++++++++
 tb/tb_ti_clock_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ti_clock_pkg.sv
// Shared definitions for the time-interleaved sampling-clock generator.
// Contents:
//   P_DEF / H_DEF   slot period and high time loaded by reset
//   N_CH_DEF        default channel count, CNT_W_DEF default counter width
//   calc_slot_w()   slot index width, never below 1
//   ti_cfg_t        config record {period, high, mask} at the default widths
package ti_clock_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;
    localparam int P_DEF     = 10;
    localparam int H_DEF     = 1;

    function automatic int calc_slot_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] high;
        logic [N_CH_DEF-1:0]  mask;
    } ti_cfg_t;

endpackage

// File: rtl/ti_slot_counter.sv
// Cycle/slot counter for the interleaved clock generator.
// Ports:
//   clk, rst      master clock, asynchronous active-low reset
//   i_en          advance enable; low holds both counters
//   i_period      active slot period (always >= 2)
//   o_cnt         cycle position within the current slot (0..period-1)
//   o_slot        current slot (0..N_CH-1)
//   o_is_wrap     last cycle of the frame (slot N_CH-1, cnt period-1)
module ti_slot_counter
    import ti_clock_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [CNT_W-1:0]  i_period,
    output logic [CNT_W-1:0]  o_cnt,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_is_wrap
);

    logic [CNT_W-1:0]  r_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic              w_slot_end;
    logic              w_last_slot;

    // >= rather than == so a stale count can never run past the period
    assign w_slot_end  = (r_cnt >= (i_period - CNT_W'(1)));
    assign w_last_slot = (r_slot == SLOT_W'(N_CH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (i_en) begin
            if (w_slot_end) begin
                r_cnt  <= '0;
                r_slot <= w_last_slot ? '0 : r_slot + SLOT_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt     = r_cnt;
    assign o_slot    = r_slot;
    assign o_is_wrap = w_slot_end & w_last_slot;

endmodule

// File: rtl/ti_clock_gen.sv
// Multi-phase sampling-clock generator: one master clock divided into N_CH
// phase-staggered sampling pulses, one per sub-ADC slot.
// Ports:
//   clk, rst       master clock, asynchronous active-low reset
//   clk_en         advance enable; low freezes counters and outputs
//   period, high   requested slot period / high time (master cycles)
//   ch_mask        per-channel enable, captured with the config
//   cfg_load       one-cycle strobe capturing period/high/ch_mask
//   clk_out        registered sampling pulses
//   slot_idx       registered slot index
//   frame_start    one-cycle pulse on slot 0, count 0
//   cfg_err        sticky: the last load was clamped
// New config is held pending and applied only on the frame wrap so that the
// pulse train never changes mid-frame.
module ti_clock_gen #(
    parameter int N_CH  = ti_clock_pkg::N_CH_DEF,
    parameter int CNT_W = ti_clock_pkg::CNT_W_DEF,
    parameter int P_DEF = ti_clock_pkg::P_DEF,
    parameter int H_DEF = ti_clock_pkg::H_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clk_en,
    input  logic [CNT_W-1:0]                           period,
    input  logic [CNT_W-1:0]                           high,
    input  logic [N_CH-1:0]                            ch_mask,
    input  logic                                       cfg_load,
    output logic [N_CH-1:0]                            clk_out,
    output logic [ti_clock_pkg::calc_slot_w(N_CH)-1:0] slot_idx,
    output logic                                       frame_start,
    output logic                                       cfg_err
);

    localparam int SLOT_W = ti_clock_pkg::calc_slot_w(N_CH);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [N_CH-1:0]  mask;
    } cfg_t;

    cfg_t              r_act;
    cfg_t              r_pend;
    logic              r_pend_valid;
    logic              r_load_d1;
    logic              r_clamp_d1;
    logic              r_cfg_err;
    logic [N_CH-1:0]   r_clk_out;
    logic [SLOT_W-1:0] r_slot_idx;
    logic              r_frame_start;

    logic [CNT_W-1:0]  w_cnt;
    logic [SLOT_W-1:0] w_slot;
    logic              w_is_wrap;
    logic              w_per_clamp;
    logic              w_high_clamp;
    cfg_t              w_cap;
    logic [N_CH-1:0]   w_clk_next;

    ti_slot_counter #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk       (clk),
        .rst       (rst),
        .i_en      (clk_en),
        .i_period  (r_act.period),
        .o_cnt     (w_cnt),
        .o_slot    (w_slot),
        .o_is_wrap (w_is_wrap)
    );

    // Clamp at capture time so the active config is always legal
    always_comb begin
        w_per_clamp  = (period < CNT_W'(2));
        w_cap.period = w_per_clamp ? CNT_W'(2) : period;
        w_high_clamp = (high >= w_cap.period);
        w_cap.high   = w_high_clamp ? (w_cap.period - CNT_W'(1)) : high;
        w_cap.mask   = ch_mask;
    end

    always_comb begin
        w_clk_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_clk_next[i] = r_act.mask[i] && (w_slot == SLOT_W'(i)) && (w_cnt < r_act.high);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_act.period  <= CNT_W'(P_DEF);
            r_act.high    <= CNT_W'(H_DEF);
            r_act.mask    <= '1;
            r_pend        <= '0;
            r_pend_valid  <= 1'b0;
            r_load_d1     <= 1'b0;
            r_clamp_d1    <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_clk_out     <= '0;
            r_slot_idx    <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (clk_en) begin
                r_clk_out     <= w_clk_next;
                r_slot_idx    <= w_slot;
                r_frame_start <= (w_slot == '0) && (w_cnt == '0);
                if (w_is_wrap && r_pend_valid) begin
                    r_act        <= r_pend;
                    r_pend_valid <= 1'b0;
                end
            end else begin
                r_frame_start <= 1'b0;
            end

            // A load on the wrap edge wins pend_valid: it waits for the next wrap
            if (cfg_load) begin
                r_pend       <= w_cap;
                r_pend_valid <= 1'b1;
            end

            // Error flag trails the capture edge by one cycle
            r_load_d1  <= cfg_load;
            r_clamp_d1 <= w_per_clamp | w_high_clamp;
            if (r_load_d1) begin
                r_cfg_err <= r_clamp_d1;
            end
        end
    end

    assign clk_out     = r_clk_out;
    assign slot_idx    = r_slot_idx;
    assign frame_start = r_frame_start;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_ti_clock_gen.sv
// Directed bench for ti_clock_gen (defaults: N_CH=4, CNT_W=8, P=10, H=1).
module tb_ti_clock_gen;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [7:0] period;
    logic [7:0] high;
    logic [3:0] ch_mask;
    logic       cfg_load;
    logic [3:0] clk_out;
    logic [1:0] slot_idx;
    logic       frame_start;
    logic       cfg_err;

    ti_clock_gen dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .period      (period),
        .high        (high),
        .ch_mask     (ch_mask),
        .cfg_load    (cfg_load),
        .clk_out     (clk_out),
        .slot_idx    (slot_idx),
        .frame_start (frame_start),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        bit         ld;
        logic [7:0] per;
        logic [7:0] hi;
        logic [3:0] msk;
        logic [3:0] e_clk;
        logic [1:0] e_slot;
        logic       e_fs;
        bit         ce;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   edge_n = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    // Drives a load strobe into edge e (leaves edge_n == e)
    task automatic load_at(input int e, input logic [7:0] p, input logic [7:0] h,
                           input logic [3:0] m);
        run_to(e - 1);
        period   = p;
        high     = h;
        ch_mask  = m;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic check(input string nm, input logic [3:0] ec, input logic [1:0] es,
                         input logic ef, input bit ce, input logic ee);
        n_vec++;
        if (clk_out !== ec || slot_idx !== es || frame_start !== ef || (ce && cfg_err !== ee)) begin
            n_bad++;
            $display("FAIL %s edge %0d: got clk_out=%b slot_idx=%0d frame_start=%b cfg_err=%b, want %b %0d %b %b",
                     nm, edge_n, clk_out, slot_idx, frame_start, cfg_err, ec, es, ef, ee);
        end
    endtask

    task automatic add(input int e, input logic [3:0] ec, input logic [1:0] es, input logic ef,
                       input logic ee);
        tbl.push_back('{e, 1'b0, 8'd0, 8'd0, 4'h0, ec, es, ef, 1'b1, ee});
    endtask

    task automatic add_ld(input int e, input logic [7:0] p, input logic [7:0] h,
                          input logic [3:0] m, input logic [3:0] ec, input logic [1:0] es,
                          input logic ef);
        tbl.push_back('{e, 1'b1, p, h, m, ec, es, ef, 1'b0, 1'b0});
    endtask

    initial begin
        rst      = 1'b0;
        clk_en   = 1'b1;
        period   = '0;
        high     = '0;
        ch_mask  = '0;
        cfg_load = 1'b0;

        // Default timing, then P=4 H=2 loaded mid-frame
        add(1,   4'b0001, 2'd0, 1'b1, 1'b0);
        add(2,   4'b0000, 2'd0, 1'b0, 1'b0);
        add(11,  4'b0010, 2'd1, 1'b0, 1'b0);
        add_ld(15, 8'd4, 8'd2, 4'b1111, 4'b0000, 2'd1, 1'b0);
        add(21,  4'b0100, 2'd2, 1'b0, 1'b0);
        add(31,  4'b1000, 2'd3, 1'b0, 1'b0);
        add(40,  4'b0000, 2'd3, 1'b0, 1'b0);
        add(41,  4'b0001, 2'd0, 1'b1, 1'b0);
        add(42,  4'b0001, 2'd0, 1'b0, 1'b0);
        add(43,  4'b0000, 2'd0, 1'b0, 1'b0);
        add(45,  4'b0010, 2'd1, 1'b0, 1'b0);
        add(49,  4'b0100, 2'd2, 1'b0, 1'b0);
        add(53,  4'b1000, 2'd3, 1'b0, 1'b0);
        add(57,  4'b0001, 2'd0, 1'b1, 1'b0);
        // Mask 0101: old mask until the wrap at edge 72
        add_ld(58, 8'd4, 8'd2, 4'b0101, 4'b0001, 2'd0, 1'b0);
        add(59,  4'b0000, 2'd0, 1'b0, 1'b0);
        add(61,  4'b0010, 2'd1, 1'b0, 1'b0);
        add(73,  4'b0001, 2'd0, 1'b1, 1'b0);
        add(77,  4'b0000, 2'd1, 1'b0, 1'b0);
        add(78,  4'b0000, 2'd1, 1'b0, 1'b0);
        add(81,  4'b0100, 2'd2, 1'b0, 1'b0);
        add(85,  4'b0000, 2'd3, 1'b0, 1'b0);
        // period=1 high=5 clamps to P=2 H=1, applied at the wrap on edge 88
        add_ld(86, 8'd1, 8'd5, 4'b1111, 4'b0000, 2'd3, 1'b0);
        add(87,  4'b0000, 2'd3, 1'b0, 1'b1);
        add(89,  4'b0001, 2'd0, 1'b1, 1'b1);
        add(90,  4'b0000, 2'd0, 1'b0, 1'b1);
        add(91,  4'b0010, 2'd1, 1'b0, 1'b1);
        add(97,  4'b0001, 2'd0, 1'b1, 1'b1);
        // Legal load clears the error, applies at the wrap on edge 104
        add_ld(98, 8'd8, 8'd2, 4'b1111, 4'b0000, 2'd0, 1'b0);
        add(99,  4'b0010, 2'd1, 1'b0, 1'b0);
        add(105, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(106, 4'b0001, 2'd0, 1'b0, 1'b0);
        add(107, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(113, 4'b0010, 2'd1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].ld) begin
                load_at(tbl[i].edge_no, tbl[i].per, tbl[i].hi, tbl[i].msk);
            end else begin
                run_to(tbl[i].edge_no);
            end
            check($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_slot, tbl[i].e_fs,
                  tbl[i].ce, tbl[i].e_err);
        end

        // Async reset mid-pulse with a clamped config pending
        load_at(121, 8'd1, 8'd0, 4'b1111);
        check("pulse_before_rst", 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check("err_before_rst", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
        run_to(1);
        check("restart_e1", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        run_to(11);
        check("restart_e11", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
        run_to(41);
        check("restart_e41", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        run_to(43);
        check("pend_discarded", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

        // clk_en freeze while clk_out[2] is high with H=3
        load_at(44, 8'd10, 8'd3, 4'b1111);
        run_to(81);
        check("h3_frame", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        run_to(101);
        check("ch2_rise", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        clk_en = 1'b0;
        tick();
        check("freeze_first", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        run_to(106);
        check("freeze_last", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        clk_en = 1'b1;
        tick();
        check("resume_1", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        check("resume_2", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        check("resume_fall", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
        run_to(125);
        check("stretched_end", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
        tick();
        check("stretched_fs", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
